// File: rtl/fpdiv_seq_if.sv
// Start/busy/done handshake bundle for the sequential single-precision divider.
// The divider takes the slave side, the requester takes the master side.
interface fpdiv_seq_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   control;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic [4:0]   flags;

    modport master (
        output start, a, b, control,
        input  busy, done, y, flags
    );

    modport slave (
        input  start, a, b, control,
        output busy, done, y, flags
    );
endinterface

// File: rtl/fpdiv_seq.sv
// Sequential IEEE-754 single-precision divider: restoring radix-2 mantissa division,
// one quotient bit per cycle, flush-to-zero inputs and outputs, four rounding modes.
module fpdiv_seq #(
    parameter int WEXP = 8,
    parameter int WSIG = 23,
    parameter int BIAS = 127
) (
    input  logic       clk,
    input  logic       reset,
    fpdiv_seq_if.slave bus
);

    localparam int W  = 1 + WEXP + WSIG;
    localparam int WM = WSIG + 1;
    localparam int WQ = WSIG + 4;
    localparam int WR = WSIG + 3;
    localparam int WE = WEXP + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UNPACK = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_ROUND  = 2'd3;

    localparam logic [W-1:0]        QNAN  = {1'b0, {WEXP{1'b1}}, 1'b1, {(WSIG-1){1'b0}}};
    localparam logic signed [WE-1:0] EMAX  = WE'((1 << WEXP) - 1);
    localparam logic signed [WE-1:0] EZERO = '0;
    localparam logic [4:0]          LAST_ITER = 5'(WQ - 1);

    logic [1:0]           r_state;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [1:0]           r_mode;
    logic                 r_sign;
    logic signed [WE-1:0] r_exp;
    logic [WR-1:0]        r_rem;
    logic [WM-1:0]        r_div;
    logic [WQ-1:0]        r_q;
    logic [4:0]           r_cnt;
    logic                 r_special;
    logic [W-1:0]         r_spec_y;
    logic [4:0]           r_spec_flags;
    logic                 r_busy;
    logic                 r_done;
    logic [W-1:0]         r_y;
    logic [4:0]           r_flags;

    // Operand classification on the registered inputs
    logic [WEXP-1:0]      w_ea;
    logic [WEXP-1:0]      w_eb;
    logic [WSIG-1:0]      w_fa;
    logic [WSIG-1:0]      w_fb;
    logic                 w_sign;
    logic                 w_a_zero;
    logic                 w_b_zero;
    logic                 w_a_inf;
    logic                 w_b_inf;
    logic                 w_a_nan;
    logic                 w_b_nan;
    logic                 w_a_snan;
    logic                 w_b_snan;
    logic signed [WE-1:0] w_ediff;
    logic                 w_special;
    logic [W-1:0]         w_spec_y;
    logic [4:0]           w_spec_flags;

    assign w_ea     = r_a[W-2 -: WEXP];
    assign w_eb     = r_b[W-2 -: WEXP];
    assign w_fa     = r_a[WSIG-1:0];
    assign w_fb     = r_b[WSIG-1:0];
    assign w_sign   = r_a[W-1] ^ r_b[W-1];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
    assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
    assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
    assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
    assign w_a_snan = w_a_nan && !w_fa[WSIG-1];
    assign w_b_snan = w_b_nan && !w_fb[WSIG-1];
    assign w_ediff  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + $signed(WE'(BIAS));

    always_comb begin
        w_special    = 1'b1;
        w_spec_y     = '0;
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_y        = QNAN;
            w_spec_flags[3] = w_a_snan || w_b_snan;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_y     = QNAN;
            w_spec_flags = 5'b01000;
        end else if (w_b_zero && !w_a_inf) begin
            w_spec_y     = {w_sign, {WEXP{1'b1}}, {WSIG{1'b0}}};
            w_spec_flags = 5'b10000;
        end else if (w_a_inf) begin
            w_spec_y = {w_sign, {WEXP{1'b1}}, {WSIG{1'b0}}};
        end else if (w_a_zero || w_b_inf) begin
            w_spec_y = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring step: the remainder always stays below twice the divisor
    logic [WR:0]   w_trial;
    logic          w_qbit;
    logic [WR-1:0] w_rem_next;

    assign w_trial    = {1'b0, r_rem} - {{(WR + 1 - WM){1'b0}}, r_div};
    assign w_qbit     = ~w_trial[WR];
    assign w_rem_next = w_qbit ? w_trial[WR-1:0] : r_rem;

    // Normalisation and rounding of the 27-bit quotient
    logic [WQ-1:0]        w_norm_q;
    logic signed [WE-1:0] w_norm_e;
    logic [WM-1:0]        w_keep;
    logic                 w_guard;
    logic                 w_rbit;
    logic                 w_sticky;
    logic                 w_lost;
    logic                 w_inc;
    logic                 w_to_inf;
    logic [WM:0]          w_mant_sum;
    logic [WSIG-1:0]      w_frac;
    logic signed [WE-1:0] w_rnd_e;
    logic [W-1:0]         w_res_y;
    logic [4:0]           w_res_flags;

    assign w_norm_q   = r_q[WQ-1] ? r_q : (r_q << 1);
    assign w_norm_e   = r_q[WQ-1] ? r_exp : (r_exp - WE'(1));
    assign w_keep     = w_norm_q[WQ-1:3];
    assign w_guard    = w_norm_q[2];
    assign w_rbit     = w_norm_q[1];
    assign w_sticky   = w_norm_q[0] | (r_rem != '0);
    assign w_lost     = w_guard | w_rbit | w_sticky;
    assign w_mant_sum = {1'b0, w_keep} + {{WM{1'b0}}, w_inc};
    assign w_frac     = w_mant_sum[WM] ? w_mant_sum[WM-1:1] : w_mant_sum[WSIG-1:0];
    assign w_rnd_e    = w_norm_e + {{(WE-1){1'b0}}, w_mant_sum[WM]};

    always_comb begin
        w_inc    = 1'b0;
        w_to_inf = 1'b0;
        case (r_mode)
            2'd0: begin
                w_inc    = w_guard & (w_rbit | w_sticky | w_keep[0]);
                w_to_inf = 1'b1;
            end
            2'd1: begin
                w_inc    = 1'b0;
                w_to_inf = 1'b0;
            end
            2'd2: begin
                w_inc    = ~r_sign & w_lost;
                w_to_inf = ~r_sign;
            end
            default: begin
                w_inc    = r_sign & w_lost;
                w_to_inf = r_sign;
            end
        endcase
    end

    always_comb begin
        w_res_y     = {r_sign, w_rnd_e[WEXP-1:0], w_frac};
        w_res_flags = {2'b00, w_lost, 2'b00};
        if (w_rnd_e >= EMAX) begin
            w_res_flags = 5'b00110;
            if (w_to_inf) begin
                w_res_y = {r_sign, {WEXP{1'b1}}, {WSIG{1'b0}}};
            end else begin
                w_res_y = {r_sign, {(WEXP-1){1'b1}}, 1'b0, {WSIG{1'b1}}};
            end
        end else if (w_rnd_e <= EZERO) begin
            w_res_flags = 5'b00101;
            w_res_y     = {r_sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= '0;
            r_flags <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_mode  <= bus.control;
                        r_busy  <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign       <= w_sign;
                    r_exp        <= w_ediff;
                    r_rem        <= {{(WR - WM){1'b0}}, 1'b1, w_fa};
                    r_div        <= {1'b1, w_fb};
                    r_q          <= '0;
                    r_cnt        <= '0;
                    r_special    <= w_special;
                    r_spec_y     <= w_spec_y;
                    r_spec_flags <= w_spec_flags;
                    r_state      <= w_special ? S_ROUND : S_DIVIDE;
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_next << 1;
                    r_q   <= {r_q[WQ-2:0], w_qbit};
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_y     <= r_special ? r_spec_y : w_res_y;
                    r_flags <= r_special ? r_spec_flags : w_res_flags;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.y     = r_y;
    assign bus.flags = r_flags;

endmodule

// File: tb/tb_fpdiv_seq.sv
// Directed bench for fpdiv_seq: exact-integer quotient model plus hand-computed vectors.
module tb_fpdiv_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpdiv_seq_if #(.W(32)) bus();

    fpdiv_seq #(.WEXP(8), .WSIG(23), .BIAS(127)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] y;
        logic [4:0]  f;
        int          tag;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    logic [31:0] last_y = '0;
    logic [4:0]  last_f = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Reference: exact long-integer quotient, then rounding from the remainder
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                  output logic [31:0] y, output logic [4:0] f, output int lat);
        int ea, eb, e;
        logic [22:0] fa, fb;
        bit az, bz, ai, bi, an, bn, asig, bsig, s, inexact, up;
        longint unsigned num, den, quo, rem, keep, low, half;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0];        fb = b[22:0];
        s  = a[31] ^ b[31];
        az = (ea == 0);  bz = (eb == 0);
        ai = (ea == 255) && (fa == 0);  bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0);  bn = (eb == 255) && (fb != 0);
        asig = an && !fa[22];           bsig = bn && !fb[22];
        lat = 2;
        f = '0;
        y = '0;
        if (an || bn) begin
            y = 32'h7FC00000; f[3] = asig || bsig; return;
        end
        if ((az && bz) || (ai && bi)) begin
            y = 32'h7FC00000; f = 5'b01000; return;
        end
        if (bz && !ai) begin
            y = {s, 8'hFF, 23'h0}; f = 5'b10000; return;
        end
        if (ai) begin
            y = {s, 8'hFF, 23'h0}; return;
        end
        if (az || bi) begin
            y = {s, 31'h0}; return;
        end
        lat = 29;
        num = longint'({1'b1, fa}) << 30;
        den = longint'({1'b1, fb});
        quo = num / den;
        rem = num % den;
        e = ea - eb + 127;
        if (quo >= 64'd1073741824) begin
            keep = quo >> 7; low = quo & 64'd127; half = 64'd64;
        end else begin
            keep = quo >> 6; low = quo & 64'd63; half = 64'd32; e = e - 1;
        end
        inexact = (low != 0) || (rem != 0);
        case (m)
            2'd0:    up = (low > half) || ((low == half) && ((rem != 0) || keep[0]));
            2'd1:    up = 1'b0;
            2'd2:    up = inexact && !s;
            default: up = inexact && s;
        endcase
        keep = keep + longint'(up);
        if (keep == 64'd16777216) begin
            keep = keep >> 1; e = e + 1;
        end
        if (e >= 255) begin
            f = 5'b00110;
            if (m == 2'd0 || (m == 2'd2 && !s) || (m == 2'd3 && s)) y = {s, 8'hFF, 23'h0};
            else y = {s, 8'hFE, 23'h7FFFFF};
        end else if (e <= 0) begin
            f = 5'b00101; y = {s, 31'h0};
        end else begin
            f = {2'b00, inexact, 2'b00};
            y = {s, e[7:0], keep[22:0]};
        end
    endfunction

    // Accept monitor: tags each accepted request with its edge number
    initial forever begin
        logic [31:0] my;
        logic [4:0]  mf;
        int          ml;
        @(posedge clk);
        cyc++;
        if (reset) begin
            q.delete();
            last_y = '0;
            last_f = '0;
        end else if (bus.start && !bus.busy) begin
            model(bus.a, bus.b, bus.control, my, mf, ml);
            q.push_back('{y: my, f: mf, tag: cyc, lat: ml});
        end
    end

    // Cycle-by-cycle compare of busy/done/y/flags against the model queue
    initial forever begin
        bit exp_done, exp_busy;
        @(negedge clk);
        if (chk_en) begin
            exp_done = (q.size() != 0) && (cyc - q[0].tag == q[0].lat);
            exp_busy = (q.size() != 0) && !exp_done;
            chk("cmp_done", 32'(bus.done), 32'(exp_done));
            chk("cmp_busy", 32'(bus.busy), 32'(exp_busy));
            if (exp_done) begin
                chk("cmp_y", bus.y, q[0].y);
                chk("cmp_flags", 32'(bus.flags), 32'(q[0].f));
                last_y = q[0].y;
                last_f = q[0].f;
                void'(q.pop_front());
            end else begin
                chk("cmp_hold_y", bus.y, last_y);
                chk("cmp_hold_flags", 32'(bus.flags), 32'(last_f));
            end
        end
    end

    // Caller is at a negedge; returns on the negedge where done is seen
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, input logic [31:0] ey, input logic [4:0] ef,
                          input int elat, input int poke);
        logic [31:0] my;
        logic [4:0]  mf;
        int          ml, k, seen;
        bit          got;
        model(a, b, m, my, mf, ml);
        chk({nm, "_model_y"}, my, ey);
        chk({nm, "_model_flags"}, 32'(mf), 32'(ef));
        chk({nm, "_model_lat"}, 32'(ml), 32'(elat));
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.control = m;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.control = 2'($urandom_range(3));
        got = 1'b0; seen = 0; k = 1;
        while (!got && k < 40) begin
            if (k == poke) begin
                bus.start = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1; seen = k;
            end
            k++;
        end
        bus.start = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no done want done within 40 cycles", nm);
        end else begin
            chk({nm, "_y"}, bus.y, ey);
            chk({nm, "_flags"}, 32'(bus.flags), 32'(ef));
            chk({nm, "_lat"}, 32'(seen), 32'(elat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.control = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_y", bus.y, 32'h0);
        chk("rst_flags", 32'(bus.flags), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op("six_two",   32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 29, 0);
        run_op("third_rne", 32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00100, 29, 0);
        run_op("third_rtz", 32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00100, 29, 0);
        run_op("third_rup", 32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAAAB, 5'b00100, 29, 0);
        run_op("third_rdn", 32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAA, 5'b00100, 29, 0);
        run_op("nthird_rup", 32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAA, 5'b00100, 29, 0);
        run_op("nthird_rdn", 32'hBF800000, 32'h40400000, 2'd3, 32'hBEAAAAAB, 5'b00100, 29, 0);
        run_op("neg_six",   32'hC0C00000, 32'h40000000, 2'd0, 32'hC0400000, 5'b00000, 29, 0);
        run_op("div_zero",  32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b10000, 2, 0);
        run_op("zero_zero", 32'h00000000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b01000, 2, 0);
        run_op("ninf_two",  32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 5'b00000, 2, 0);
        run_op("inf_zero",  32'h7F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b00000, 2, 0);
        run_op("inf_inf",   32'h7F800000, 32'hFF800000, 2'd0, 32'h7FC00000, 5'b01000, 2, 0);
        run_op("one_inf",   32'hBF800000, 32'h7F800000, 2'd0, 32'h80000000, 5'b00000, 2, 0);
        run_op("qnan",      32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b00000, 2, 0);
        run_op("snan",      32'h3F800000, 32'h7F800001, 2'd0, 32'h7FC00000, 5'b01000, 2, 0);
        run_op("denorm",    32'h00000001, 32'h3F800000, 2'd0, 32'h00000000, 5'b00000, 2, 0);
        run_op("ovf_rne",   32'h7F7FFFFF, 32'h3F000000, 2'd0, 32'h7F800000, 5'b00110, 29, 0);
        run_op("ovf_rtz",   32'h7F7FFFFF, 32'h3F000000, 2'd1, 32'h7F7FFFFF, 5'b00110, 29, 0);
        run_op("novf_rup",  32'hFF7FFFFF, 32'h3F000000, 2'd2, 32'hFF7FFFFF, 5'b00110, 29, 0);
        run_op("novf_rdn",  32'hFF7FFFFF, 32'h3F000000, 2'd3, 32'hFF800000, 5'b00110, 29, 0);
        run_op("max_exp",   32'h7F000000, 32'h3F800000, 2'd0, 32'h7F000000, 5'b00000, 29, 0);
        run_op("unf",       32'h00800000, 32'h40000000, 2'd0, 32'h00000000, 5'b00101, 29, 0);
        run_op("min_norm",  32'h01000000, 32'h40000000, 2'd0, 32'h00800000, 5'b00000, 29, 0);
        run_op("ignored_start", 32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00100, 29, 10);

        // Abort an operation with reset part-way through the divide
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000; bus.control = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_y", bus.y, 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        repeat (35) @(negedge clk);
        run_op("after_reset", 32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 29, 0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
